// File: rtl/qbus_pkg.sv
// Shared definitions for the Qbus DMA master-cycle engine.
//   - state_e       : master-cycle sequencer states
//   - BdalWidth     : width of the multiplexed BDAL bus
//   - DataWidth     : width of the data portion of BDAL
//   - T*Default     : default timing values in clocks (100 MHz reference)
//   - at_least_one  : clamps a timing value so that 0 behaves as 1
package qbus_pkg;

  localparam int unsigned BdalWidth = 22;
  localparam int unsigned DataWidth = 16;

  localparam int unsigned TAsetupDefault  = 15;
  localparam int unsigned TAholdDefault   = 10;
  localparam int unsigned TDsetupDefault  = 10;
  localparam int unsigned TSettleDefault  = 20;
  localparam int unsigned TDholdDefault   = 10;
  localparam int unsigned TTimeoutDefault = 1000;

  typedef enum logic [3:0] {
    StIdle,
    StAsetup,
    StAhold,
    StDsetup,
    StStrobe,
    StSettle,
    StDhold,
    StRplyneg,
    StSyncoff
  } state_e;

  function automatic int unsigned at_least_one(int unsigned t);
    return (t == 0) ? 1 : t;
  endfunction

endpackage

// File: rtl/qbus_sync2.sv
// Two-flop synchronizer for asynchronous Qbus inputs.
// Resets to all ones, which is the idle (negated) level of the active-low bus.
//   clock : system clock
//   rstn  : asynchronous active-low reset
//   d     : raw asynchronous input
//   q     : synchronized output
module qbus_sync2 #(
  parameter int unsigned Width = 1
) (
  input  logic             clock,
  input  logic             rstn,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] meta_q;
  logic [Width-1:0] sync_q;

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/qbus_dma_sequencer.sv
// Qbus DMA master-cycle engine. Runs one DATI / DATO / DATOB bus cycle per
// accepted start while mastership (bsack) is held, generating BSYNC/BDIN/BDOUT/
// BWTBT and BDAL drive, handshaking on BRPLY, and reporting done/timeout.
//   clock, rstn          : clock, asynchronous active-low reset
//   start                : one-cycle request, accepted only in idle with bsack high
//   write, byte_op       : cycle type (byte_op stands in for "byte", a reserved word)
//   addr, wdata          : bus address and write data
//   bsack                : mastership held; loss aborts the cycle
//   BRPLYf, BDALf_IN     : raw active-low bus inputs
//   BSYNCg..BWTBTg       : registered gate drives
//   BDALf_OUT, Outbound  : true-polarity BDAL value and driver enable
//   rdata, busy, done,   : read data, activity, completion pulse,
//   timeout              : sticky error flag (cleared on next accepted start)
module qbus_dma_sequencer
  import qbus_pkg::*;
#(
  parameter int unsigned T_ASETUP  = TAsetupDefault,
  parameter int unsigned T_AHOLD   = TAholdDefault,
  parameter int unsigned T_DSETUP  = TDsetupDefault,
  parameter int unsigned T_SETTLE  = TSettleDefault,
  parameter int unsigned T_DHOLD   = TDholdDefault,
  parameter int unsigned T_TIMEOUT = TTimeoutDefault,
  parameter int unsigned CW        = 10
) (
  input  logic                 clock,
  input  logic                 rstn,
  input  logic                 start,
  input  logic                 write,
  input  logic                 byte_op,
  input  logic [BdalWidth-1:0] addr,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 bsack,
  input  logic                 BRPLYf,
  input  logic [BdalWidth-1:0] BDALf_IN,
  output logic                 BSYNCg,
  output logic                 BDINg,
  output logic                 BDOUTg,
  output logic                 BWTBTg,
  output logic [BdalWidth-1:0] BDALf_OUT,
  output logic                 Outbound,
  output logic [DataWidth-1:0] rdata,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout
);

  localparam logic [CW-1:0] LdAsetup  = CW'(at_least_one(T_ASETUP));
  localparam logic [CW-1:0] LdAhold   = CW'(at_least_one(T_AHOLD));
  localparam logic [CW-1:0] LdDsetup  = CW'(at_least_one(T_DSETUP));
  localparam logic [CW-1:0] LdSettle  = CW'(at_least_one(T_SETTLE));
  localparam logic [CW-1:0] LdDhold   = CW'(at_least_one(T_DHOLD));
  localparam logic [CW-1:0] LdTimeout = CW'(at_least_one(T_TIMEOUT));
  localparam logic [CW-1:0] CntOne    = CW'(1);

  function automatic logic [CW-1:0] load_for(state_e s);
    case (s)
      StAsetup:            return LdAsetup;
      StAhold:             return LdAhold;
      StDsetup:            return LdDsetup;
      StStrobe, StRplyneg: return LdTimeout;
      StSettle:            return LdSettle;
      StDhold:             return LdDhold;
      default:             return CntOne;
    endcase
  endfunction

  // Only the data half of BDAL is read back.
  logic unused_bdal;
  assign unused_bdal = ^BDALf_IN[BdalWidth-1:DataWidth];

  logic rply_sync;
  logic rply;

  qbus_sync2 #(
    .Width(1)
  ) u_rply_sync (
    .clock(clock),
    .rstn (rstn),
    .d    (BRPLYf),
    .q    (rply_sync)
  );

  assign rply = ~rply_sync;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BdalWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic                 byte_q, byte_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;
  logic                 timeout_q, timeout_d;
  logic                 abort;

  logic                 bsync_q, bsync_d;
  logic                 bdin_q, bdin_d;
  logic                 bdout_q, bdout_d;
  logic                 bwtbt_q, bwtbt_d;
  logic [BdalWidth-1:0] bdal_q, bdal_d;
  logic                 outbound_q, outbound_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // State and transfer registers
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      byte_q    <= 1'b0;
      rdata_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      byte_q    <= byte_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    byte_d    = byte_q;
    rdata_d   = rdata_q;
    timeout_d = timeout_q;
    abort     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && bsack) begin
          state_d   = StAsetup;
          addr_d    = addr;
          wdata_d   = wdata;
          write_d   = write;
          byte_d    = byte_op;
          timeout_d = 1'b0;
        end
      end
      StAsetup: begin
        if (cnt_q == CntOne) state_d = StAhold;
        else                 cnt_d = cnt_q - CntOne;
      end
      StAhold: begin
        if (cnt_q == CntOne) state_d = StDsetup;
        else                 cnt_d = cnt_q - CntOne;
      end
      StDsetup: begin
        if (cnt_q == CntOne) state_d = StStrobe;
        else                 cnt_d = cnt_q - CntOne;
      end
      StStrobe: begin
        // Level-sensitive: a reply already present on entry is taken at once.
        if (rply) begin
          state_d = StSettle;
        end else if (cnt_q == CntOne) begin
          timeout_d = 1'b1;
          state_d   = StSyncoff;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StSettle: begin
        if (cnt_q == CntOne) begin
          if (!write_q) rdata_d = ~BDALf_IN[DataWidth-1:0];
          state_d = write_q ? StDhold : StRplyneg;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StDhold: begin
        if (cnt_q == CntOne) state_d = StRplyneg;
        else                 cnt_d = cnt_q - CntOne;
      end
      StRplyneg: begin
        if (!rply) begin
          state_d = StSyncoff;
        end else if (cnt_q == CntOne) begin
          timeout_d = 1'b1;
          state_d   = StSyncoff;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StSyncoff: state_d = StIdle;
      default:   state_d = StIdle;
    endcase

    // Losing mastership mid-cycle; SYNCOFF already finishes with its own done.
    if (state_q != StIdle && state_q != StSyncoff && !bsack) begin
      state_d   = StIdle;
      rdata_d   = rdata_q;
      timeout_d = 1'b1;
      abort     = 1'b1;
    end

    if (state_d != state_q) cnt_d = load_for(state_d);
  end

  // Output decode from the next state so every bus output is a plain register.
  always_comb begin
    bsync_d    = 1'b0;
    bdin_d     = 1'b0;
    bdout_d    = 1'b0;
    bwtbt_d    = 1'b0;
    bdal_d     = '0;
    outbound_d = 1'b0;

    unique case (state_d)
      StAsetup, StAhold: begin
        bsync_d    = (state_d == StAhold);
        bdal_d     = addr_d;
        outbound_d = 1'b1;
        bwtbt_d    = write_d;
      end
      StDsetup, StStrobe, StSettle, StDhold: begin
        bsync_d = 1'b1;
        if (state_d == StStrobe || state_d == StSettle) begin
          bdin_d  = ~write_d;
          bdout_d = write_d;
        end
        if (write_d) begin
          bdal_d     = {{(BdalWidth - DataWidth){1'b0}}, wdata_d};
          outbound_d = 1'b1;
          bwtbt_d    = byte_d;
        end
      end
      StRplyneg: bsync_d = 1'b1;
      default: ;
    endcase

    busy_d = (state_d != StIdle);
    done_d = (state_d == StSyncoff) || abort;
  end

  // Output registers
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      bsync_q    <= 1'b0;
      bdin_q     <= 1'b0;
      bdout_q    <= 1'b0;
      bwtbt_q    <= 1'b0;
      bdal_q     <= '0;
      outbound_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      bsync_q    <= bsync_d;
      bdin_q     <= bdin_d;
      bdout_q    <= bdout_d;
      bwtbt_q    <= bwtbt_d;
      bdal_q     <= bdal_d;
      outbound_q <= outbound_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign BSYNCg    = bsync_q;
  assign BDINg     = bdin_q;
  assign BDOUTg    = bdout_q;
  assign BWTBTg    = bwtbt_q;
  assign BDALf_OUT = bdal_q;
  assign Outbound  = outbound_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_qbus_dma_sequencer.sv
module tb_qbus_dma_sequencer;

  logic        clock = 1'b0;
  logic        rstn;
  logic        start;
  logic        write;
  logic        byte_op;
  logic [21:0] addr;
  logic [15:0] wdata;
  logic        bsack;
  logic        BRPLYf;
  logic [21:0] BDALf_IN;
  logic        BSYNCg, BDINg, BDOUTg, BWTBTg, Outbound, busy, done, timeout;
  logic [21:0] BDALf_OUT;
  logic [15:0] rdata;

  qbus_dma_sequencer dut (
    .clock    (clock),
    .rstn     (rstn),
    .start    (start),
    .write    (write),
    .byte_op  (byte_op),
    .addr     (addr),
    .wdata    (wdata),
    .bsack    (bsack),
    .BRPLYf   (BRPLYf),
    .BDALf_IN (BDALf_IN),
    .BSYNCg   (BSYNCg),
    .BDINg    (BDINg),
    .BDOUTg   (BDOUTg),
    .BWTBTg   (BWTBTg),
    .BDALf_OUT(BDALf_OUT),
    .Outbound (Outbound),
    .rdata    (rdata),
    .busy     (busy),
    .done     (done),
    .timeout  (timeout)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] rdata;
    logic        timeout;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_done = 0;
  int          n_mark = 0;
  logic [15:0] rdata_m = 16'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (rstn === 1'b1 && done === 1'b1) begin
      n_done++;
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_rdata", {16'b0, rdata}, {16'b0, e.rdata});
        chk("done_timeout", {31'b0, timeout}, {31'b0, e.timeout});
      end
    end
  end

  task automatic push_exp(input logic [15:0] rd, input logic to);
    exp_t e;
    e.rdata   = rd;
    e.timeout = to;
    sb.push_back(e);
  endtask

  // Drive a one-cycle start; returns at the first negedge after the accepting edge.
  task automatic kick(input logic [21:0] a, input logic [15:0] wd, input logic wr,
                      input logic bt);
    n_mark  = n_done;
    addr    = a;
    wdata   = wd;
    write   = wr;
    byte_op = bt;
    start   = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (n_done == n_mark && i < 3000) begin
      @(negedge clock);
      i++;
    end
    repeat (3) @(negedge clock);
    chk(tag, n_done - n_mark, 32'd1);
  endtask

  task automatic wait_strobe(input string tag);
    int i;
    i = 0;
    while (!(BDINg || BDOUTg) && i < 200) begin
      @(negedge clock);
      i++;
    end
    chk(tag, {31'b0, (BDINg || BDOUTg)}, 32'd1);
  endtask

  task automatic wait_strobe_off(input string tag);
    int i;
    i = 0;
    while ((BDINg || BDOUTg) && i < 200) begin
      @(negedge clock);
      i++;
    end
    chk(tag, {31'b0, (BDINg || BDOUTg)}, 32'd0);
  endtask

  initial begin
    int cnt;
    rstn     = 1'b0;
    start    = 1'b0;
    write    = 1'b0;
    byte_op  = 1'b0;
    addr     = '0;
    wdata    = '0;
    bsack    = 1'b1;
    BRPLYf   = 1'b1;
    BDALf_IN = '1;
    repeat (3) @(negedge clock);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_outbound", {31'b0, Outbound}, 32'd0);
    chk("rst_bsync", {31'b0, BSYNCg}, 32'd0);
    chk("rst_bdal", {10'b0, BDALf_OUT}, 32'd0);
    chk("rst_rdata", {16'b0, rdata}, 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clock);

    // DATI with a 300 ns reply
    rdata_m = 16'o123456;
    push_exp(rdata_m, 1'b0);
    kick(22'o17772150, 16'h0, 1'b0, 1'b0);
    chk("dati_busy", {31'b0, busy}, 32'd1);
    chk("dati_addr", {10'b0, BDALf_OUT}, {10'b0, 22'o17772150});
    chk("dati_outbound_a", {31'b0, Outbound}, 32'd1);
    chk("dati_bwtbt_a", {31'b0, BWTBTg}, 32'd0);
    repeat (14) @(negedge clock);
    chk("dati_bsync_pre", {31'b0, BSYNCg}, 32'd0);
    @(negedge clock);
    chk("dati_bsync_15", {31'b0, BSYNCg}, 32'd1);
    wait_strobe("dati_bdin_rise");
    chk("dati_outbound_d", {31'b0, Outbound}, 32'd0);
    repeat (30) @(negedge clock);
    BRPLYf   = 1'b0;
    BDALf_IN = ~{6'b0, 16'o123456};
    wait_strobe_off("dati_bdin_fall");
    BRPLYf   = 1'b1;
    BDALf_IN = '1;
    wait_done("dati_done_once");
    chk("dati_rdata", {16'b0, rdata}, {16'b0, 16'o123456});
    chk("dati_timeout", {31'b0, timeout}, 32'd0);

    // DATO word
    push_exp(rdata_m, 1'b0);
    kick(22'o1234, 16'hA5C3, 1'b1, 1'b0);
    chk("dato_bwtbt_a", {31'b0, BWTBTg}, 32'd1);
    wait_strobe("dato_bdout_rise");
    chk("dato_bdin", {31'b0, BDINg}, 32'd0);
    chk("dato_bdal", {10'b0, BDALf_OUT}, 32'h0A5C3);
    chk("dato_bwtbt_d", {31'b0, BWTBTg}, 32'd0);
    BRPLYf = 1'b0;
    wait_strobe_off("dato_bdout_fall");
    BRPLYf = 1'b1;
    chk("dato_hold_first", {10'b0, BDALf_OUT}, 32'h0A5C3);
    repeat (9) @(negedge clock);
    chk("dato_hold_last", {10'b0, BDALf_OUT}, 32'h0A5C3);
    chk("dato_hold_oe", {31'b0, Outbound}, 32'd1);
    @(negedge clock);
    chk("dato_release", {31'b0, Outbound}, 32'd0);
    wait_done("dato_done_once");

    // DATOB
    push_exp(rdata_m, 1'b0);
    kick(22'o1235, 16'h005A, 1'b1, 1'b1);
    chk("datob_bwtbt_a", {31'b0, BWTBTg}, 32'd1);
    wait_strobe("datob_bdout_rise");
    chk("datob_bwtbt_d", {31'b0, BWTBTg}, 32'd1);
    chk("datob_bdal", {10'b0, BDALf_OUT}, 32'h0005A);
    BRPLYf = 1'b0;
    wait_strobe_off("datob_bdout_fall");
    BRPLYf = 1'b1;
    wait_done("datob_done_once");

    // No reply: strobe held for the full timeout
    push_exp(rdata_m, 1'b1);
    kick(22'o17000000, 16'h0, 1'b0, 1'b0);
    wait_strobe("nxm_bdin_rise");
    cnt = 0;
    while (BDINg && cnt < 1100) begin
      cnt++;
      @(negedge clock);
    end
    chk("nxm_strobe_len", cnt, 32'd1000);
    chk("nxm_done", {31'b0, done}, 32'd1);
    chk("nxm_timeout", {31'b0, timeout}, 32'd1);
    chk("nxm_bsync_off", {31'b0, BSYNCg}, 32'd0);
    chk("nxm_outbound_off", {31'b0, Outbound}, 32'd0);
    wait_done("nxm_done_once");
    chk("nxm_sticky", {31'b0, timeout}, 32'd1);

    // BRPLY stuck asserted: reply honoured on STROBE entry, RPLYNEG times out
    rdata_m = 16'h1357;
    push_exp(rdata_m, 1'b1);
    BRPLYf   = 1'b0;
    BDALf_IN = ~{6'b0, 16'h1357};
    kick(22'o2000, 16'h0, 1'b0, 1'b0);
    chk("stuck_timeout_cleared", {31'b0, timeout}, 32'd0);
    wait_strobe("stuck_bdin_rise");
    wait_strobe_off("stuck_bdin_fall");
    chk("stuck_bsync_held", {31'b0, BSYNCg}, 32'd1);
    wait_done("stuck_done_once");
    chk("stuck_bsync_off", {31'b0, BSYNCg}, 32'd0);
    chk("stuck_rdata", {16'b0, rdata}, 32'h1357);
    BRPLYf   = 1'b1;
    BDALf_IN = '1;
    repeat (5) @(negedge clock);

    // bsack lost during STROBE
    push_exp(rdata_m, 1'b1);
    kick(22'o3000, 16'h0, 1'b0, 1'b0);
    wait_strobe("abort_bdin_rise");
    bsack = 1'b0;
    @(negedge clock);
    chk("abort_bdin", {31'b0, BDINg}, 32'd0);
    chk("abort_bsync", {31'b0, BSYNCg}, 32'd0);
    chk("abort_outbound", {31'b0, Outbound}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd1);
    chk("abort_timeout", {31'b0, timeout}, 32'd1);
    bsack = 1'b1;
    wait_done("abort_done_once");

    // Reset pulsed during AHOLD
    kick(22'o4000, 16'h0, 1'b0, 1'b0);
    cnt = 0;
    while (!BSYNCg && cnt < 100) begin
      cnt++;
      @(negedge clock);
    end
    chk("rstmid_bsync_seen", {31'b0, BSYNCg}, 32'd1);
    rstn = 1'b0;
    #1;
    chk("rstmid_bsync", {31'b0, BSYNCg}, 32'd0);
    chk("rstmid_outbound", {31'b0, Outbound}, 32'd0);
    chk("rstmid_busy", {31'b0, busy}, 32'd0);
    chk("rstmid_bdal", {10'b0, BDALf_OUT}, 32'd0);
    chk("rstmid_rdata", {16'b0, rdata}, 32'd0);
    rdata_m = 16'h0;
    @(negedge clock);
    rstn = 1'b1;
    repeat (5) @(negedge clock);
    chk("rstmid_no_done", n_done - n_mark, 32'd0);

    // start without mastership is ignored
    bsack = 1'b0;
    kick(22'o5000, 16'h0, 1'b0, 1'b0);
    chk("nosack_busy", {31'b0, busy}, 32'd0);
    repeat (30) @(negedge clock);
    chk("nosack_outbound", {31'b0, Outbound}, 32'd0);
    chk("nosack_no_done", n_done - n_mark, 32'd0);
    bsack = 1'b1;

    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
